// File: rtl/serial_alu_6_bit.sv
// Bit-serial ALU: one bit per clock through a single 1-bit slice, LSB first.
// Optional zero flag output enabled by defining SERIAL_ALU_ZERO_FLAG_EN.
module serial_alu_6_bit #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    input  logic [3:0]       ALUop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpNor = 4'b1100;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [3:0]       op;
    logic             cy;
    logic [CntW-1:0]  cnt;

    logic             bit_a;
    logic             bit_b;
    logic             bit_r;
    logic             cy_next;
    logic             is_arith;
    logic             last_bit;
    logic [WIDTH-1:0] new_word;

    always_comb begin
        bit_a    = a_sh[0];
        bit_b    = (op == OpSub) ? ~b_sh[0] : b_sh[0];
        is_arith = (op == OpAdd) || (op == OpSub);
        cy_next  = (bit_a & bit_b) | (bit_a & cy) | (bit_b & cy);
        case (op)
            OpAnd:        bit_r = bit_a & bit_b;
            OpOr:         bit_r = bit_a | bit_b;
            OpAdd, OpSub: bit_r = bit_a ^ bit_b ^ cy;
            OpNor:        bit_r = ~(bit_a | bit_b);
            default:      bit_r = 1'b0;
        endcase
        // Result bits enter at the MSB, so after WIDTH shifts bit 0 sits at the bottom.
        new_word = {bit_r, res_sh};
        last_bit = (cnt == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carryout <= 1'b0;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            op       <= '0;
            cy       <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zero     <= 1'b1;
`endif
        end else begin
            case (state)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        op    <= ALUop;
                        cy    <= C;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= StShift;
                    end else begin
                        state <= StIdle;
                    end
                end
                StShift: begin
                    res_sh <= new_word[WIDTH-1:1];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (is_arith) begin
                        cy <= cy_next;
                    end
                    cnt <= cnt + CntW'(1);
                    if (last_bit) begin
                        state    <= StDone;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= new_word;
                        carryout <= is_arith & cy_next;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                        zero     <= (new_word == '0);
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_6_bit.sv
// Self-checking bench for serial_alu_6_bit against an arithmetic reference model.
module tb_serial_alu_6_bit;

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] A;
    logic [5:0] B;
    logic       C;
    logic [3:0] ALUop;
    logic       busy;
    logic       done;
    logic [5:0] result;
    logic       carryout;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic       zero;
`endif

    int total = 0;
    int bad   = 0;

    // Done is seen on the 7th falling edge after the start edge; busy on 6 of them.
    localparam int ExpLat  = 7;
    localparam int ExpBusy = 6;

    serial_alu_6_bit #(.WIDTH(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .A       (A),
        .B       (B),
        .C       (C),
        .ALUop   (ALUop),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carryout(carryout)
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        ,
        .zero    (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] model(input logic [5:0] a, input logic [5:0] b,
                                         input logic c, input logic [3:0] op);
        int unsigned s;
        case (op)
            4'b0000: return {1'b0, a & b};
            4'b0001: return {1'b0, a | b};
            4'b1100: return {1'b0, ~(a | b)};
            4'b0010: begin
                s = int'(a) + int'(b) + int'(c);
                return s[6:0];
            end
            4'b0110: begin
                s = int'(a) + (63 - int'(b)) + int'(c);
                return s[6:0];
            end
            default: return 7'd0;
        endcase
    endfunction

    // Issues one operation from a falling edge and returns what the DUT produced.
    task automatic do_op(input logic [5:0] a, input logic [5:0] b, input logic c,
                         input logic [3:0] op, output logic [5:0] res, output logic co,
                         output int lat, output int busy_cnt);
        A = a; B = b; C = c; ALUop = op; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 6'($urandom); B = 6'($urandom); C = 1'($urandom); ALUop = 4'($urandom);
        lat = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
        res = result;
        co  = carryout;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; A = '0; B = '0; C = 1'b0; ALUop = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, result, carryout} !== 9'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b result=%0d co=%b, want all 0",
                     busy, done, result, carryout);
        end
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        total++;
        if (zero !== 1'b1) begin
            bad++;
            $display("FAIL reset_zero: got %b want 1", zero);
        end
`endif
    endtask

    task automatic test_directed();
        logic [5:0] a_t[10] = '{25, 63, 20, 20, 42, 42, 42, 42, 0, 63};
        logic [5:0] b_t[10] = '{14,  1,  5,  5, 15, 15, 15, 15, 0, 63};
        logic       c_t[10] = '{ 0,  0,  1,  0,  0,  0,  0,  0, 1,  1};
        logic [3:0] o_t[10] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000,
                                4'b0001, 4'b1100, 4'b0111, 4'b0010, 4'b0010};
        logic [5:0] r_t[10] = '{39, 0, 15, 14, 6'h0A, 6'h2F, 6'h10, 0, 1, 63};
        logic       k_t[10] = '{ 0, 1,  1,  1, 0, 0, 0, 0, 0, 1};
        logic [5:0] res;
        logic       co;
        int         lat, bc;
        for (int i = 0; i < 10; i++) begin
            do_op(a_t[i], b_t[i], c_t[i], o_t[i], res, co, lat, bc);
            total++;
            if (res !== r_t[i] || co !== k_t[i] || lat != ExpLat || bc != ExpBusy) begin
                bad++;
                $display("FAIL directed_%0d: got res=%0d co=%b lat=%0d busy=%0d, want res=%0d co=%b lat=%0d busy=%0d",
                         i, res, co, lat, bc, r_t[i], k_t[i], ExpLat, ExpBusy);
            end
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            total++;
            if (zero !== (r_t[i] == 6'd0)) begin
                bad++;
                $display("FAIL directed_zero_%0d: got %b want %b", i, zero, r_t[i] == 6'd0);
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [3:0] ops[6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0000};
        logic [5:0] a, b, res;
        logic       c, co;
        logic [3:0] op;
        logic [6:0] exp;
        int         lat, bc;
        for (int i = 0; i < 40; i++) begin
            a = 6'($urandom); b = 6'($urandom); c = 1'($urandom);
            op = ops[$urandom_range(0, 5)];
            if (i % 8 == 7) op = 4'($urandom);
            exp = model(a, b, c, op);
            do_op(a, b, c, op, res, co, lat, bc);
            total++;
            if (res !== exp[5:0] || co !== exp[6] || lat != ExpLat) begin
                bad++;
                $display("FAIL random_%0d op=%b a=%0d b=%0d c=%b: got res=%0d co=%b lat=%0d, want res=%0d co=%b lat=%0d",
                         i, op, a, b, c, res, co, lat, exp[5:0], exp[6], ExpLat);
            end
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            total++;
            if (zero !== (exp[5:0] == 6'd0)) begin
                bad++;
                $display("FAIL random_zero_%0d: got %b want %b", i, zero, exp[5:0] == 6'd0);
            end
`endif
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        logic [5:0] res;
        logic       co;
        int         lat, bc;
        int         seen;
        A = 6'd1; B = 6'd1; C = 1'b0; ALUop = 4'b0010; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        A = 6'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (seen != 1 || result !== 6'd2 || carryout !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored: got done=%0d res=%0d co=%b, want done=1 res=2 co=0",
                     seen, result, carryout);
        end
        // Start asserted in the done cycle launches the next operation at once.
        do_op(6'd5, 6'd9, 1'b0, 4'b0010, res, co, lat, bc);
        total++;
        if (res !== 6'd14 || co !== 1'b0 || lat != ExpLat) begin
            bad++;
            $display("FAIL start_in_done: got res=%0d co=%b lat=%0d, want res=14 co=0 lat=%0d",
                     res, co, lat, ExpLat);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 6'd14) begin
            bad++;
            $display("FAIL done_pulse_hold: got done=%b busy=%b res=%0d, want done=0 busy=0 res=14",
                     done, busy, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] res;
        logic       co;
        logic [6:0] exp;
        int         lat, bc;
        logic [5:0] a, b;
        for (int i = 0; i < 4; i++) begin
            a = 6'($urandom); b = 6'($urandom);
            exp = model(a, b, 1'b1, 4'b0110);
            do_op(a, b, 1'b1, 4'b0110, res, co, lat, bc);
            total++;
            if (res !== exp[5:0] || co !== exp[6] || lat != ExpLat || bc != ExpBusy) begin
                bad++;
                $display("FAIL back_to_back_%0d: got res=%0d co=%b lat=%0d busy=%0d, want res=%0d co=%b lat=%0d busy=%0d",
                         i, res, co, lat, bc, exp[5:0], exp[6], ExpLat, ExpBusy);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [5:0] res;
        logic       co;
        int         lat, bc;
        // Leave a nonzero result and carry behind so the reset clear is observable.
        do_op(6'd63, 6'd63, 1'b1, 4'b0010, res, co, lat, bc);
        @(negedge clk);
        A = 6'd30; B = 6'd30; C = 1'b0; ALUop = 4'b0010; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, result, carryout} !== 9'd0) begin
            bad++;
            $display("FAIL reset_mid_op: got busy=%b done=%b res=%0d co=%b, want all 0",
                     busy, done, result, carryout);
        end
        do_op(6'd10, 6'd10, 1'b0, 4'b0010, res, co, lat, bc);
        total++;
        if (res !== 6'd20 || co !== 1'b0 || lat != ExpLat) begin
            bad++;
            $display("FAIL after_reset_add: got res=%0d co=%b lat=%0d, want res=20 co=0 lat=%0d",
                     res, co, lat, ExpLat);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
